dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory responder for the MEM stage of the pipelined CPU.
- Services load/store requests from the pipeline with a fixed multi-cycle latency and stalls the pipeline through `mem_stall` while busy.
- Returns aligned, extended load data on `datamem_out`, which feeds the write-back MemtoReg select.
- Handles byte, half and word accesses, little-endian, with misalignment detection.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from MEM stage.
- mem_write  input  1  store request from MEM stage.
- addr  input  32  byte address (ALU result).
- store_data  input  32  store operand (rt value).
- mem_size  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- load_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
- datamem_out  output  32  load result to write-back.
- mem_stall  output  1  holds PC and IF/ID/EX/MEM registers while high.
- misalign_err  output  1  one-cycle pulse for a misaligned access.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, mem_stall=0, datamem_out=0, misalign_err=0, counter=0.
  - Memory contents are not cleared.
  - rst asserted mid-access aborts it: state returns to IDLE and any pending store is dropped (no array write).
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read|mem_write, mem_stall=1 combinationally in the same cycle.
  - Latch addr, store_data, mem_size, load_unsigned and operation.
  - Load counter with WAIT_CYCLES; go to BUSY.
  - With no request: mem_stall=0 and outputs hold.
- BUSY:
  - mem_stall=1; counter decrements each cycle.
  - When counter==1, go to DONE. On that edge, the store commits to the array, or read data is registered into datamem_out.
- DONE:
  - mem_stall=0; datamem_out is valid for this cycle and holds until the next load completes.
  - Request inputs are ignored in DONE, because they still belong to the retiring instruction.
  - Next state is IDLE unconditionally.
- Latency: mem_stall is high for WAIT_CYCLES+1 cycles; data is valid in cycle WAIT_CYCLES+1 counted from request cycle 0. Default: stall in cycles 0–2, DONE in cycle 3.
- Back-to-back requests: minimum spacing is request cycle, BUSY cycles, DONE, IDLE. A new request is accepted in the IDLE cycle after DONE.
- Simultaneous mem_read and mem_write: treated as a store; the read is ignored.
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2]; upper bits are ignored (wrap-around).
  - Byte lane = addr[1:0], little-endian.
- Stores:
  - byte: store_data[7:0] goes to lane addr[1:0].
  - half: store_data[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - word: the full word is written.
  - Other lanes are unchanged.
- Loads:
  - The selected byte/half is shifted to bit 0.
  - It is then sign- or zero-extended per the latched load_unsigned.
- Misalignment (half with addr[0]=1; word with addr[1:0]!=0):
  - No array access.
  - misalign_err=1 in DONE only.
  - For a misaligned load, datamem_out=0.
  - Stall timing is identical to a legal access.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings.
  - The state encoding (IDLE/BUSY/DONE).
  - A function computing the 4-bit byte-enable from size and addr[1:0].
- Sub-module dmem_array: single-port synchronous RAM with 4-bit byte-enable write and registered read, 2^ADDR_WIDTH×32.
  - The controller issues the array read one cycle before DONE so the registered output aligns with the BUSY→DONE capture.

Test Plan:
- Word store/load: store 0xDEADBEEF at 0x10, then load word at 0x10 → datamem_out=0xDEADBEEF in DONE. mem_stall is high for exactly 3 cycles per access (default).
- Byte store with signed and unsigned loads:
  - Word 0 preset to 0x00000000; store byte 0x85 at addr 0x2 → word 0 = 0x00850000.
  - Signed byte load at 0x2 → 0xFFFFFF85.
  - Unsigned byte load at 0x2 → 0x00000085.
- Half access: store half 0x8001 at 0x6, then load signed half at 0x6 → 0xFFFF8001. Word 1 lanes 0/1 are unchanged.
- Misaligned accesses:
  - Word load at 0x13 → misalign_err pulses 1 cycle in DONE, datamem_out=0.
  - Half store at 0x5 → memory unchanged (verified by a subsequent word read).
- Reset mid-access: issue a store of 0x12345678 to 0x20 and assert rst in BUSY cycle 1 → next cycle mem_stall=0, state IDLE. A later load of 0x20 returns the old value.
- Simultaneous requests and wrap-around:
  - mem_read=mem_write=1 with 0xA5A5A5A5 at 0x40 → a store occurs.
  - Word load at 0x40 + (1<<(ADDR_WIDTH+2)) → 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Encodings and lane helpers shared by the data-memory controller and its array.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        wr;
  } req_t;

  // Size 11 falls into the default arm everywhere and behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = lane[0];
      default:   mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lane,
                                          input logic uns, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we_be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we_be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Fixed-latency data-memory responder for the MEM stage: stalls the pipeline
// while an access is in flight and returns aligned, extended load data.
//
//   state | meaning
//   IDLE  | waiting; a request stalls this cycle and is latched
//   BUSY  | counting down; last cycle commits store / captures load
//   DONE  | stall released, load result and misalign pulse visible
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  output logic [31:0] datamem_out,
  output logic        mem_stall,
  output logic        misalign_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic [31:0] dout_q, dout_d;
  logic        mis_q, mis_d;

  logic                  req_in;
  logic                  last_busy;
  logic                  req_mis;
  logic                  arr_en;
  logic [3:0]            arr_be;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [31:0]           arr_wdata;
  logic [31:0]           arr_rdata;
  logic                  unused_addr_hi;

  assign req_in    = mem_read | mem_write;
  assign last_busy = (state_q == ST_BUSY) && (cnt_q <= 4'd1);
  assign req_mis   = misaligned(req_q.size, req_q.addr[1:0]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    dout_d    = dout_q;
    mis_d     = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          mem_stall   = 1'b1;
          req_d.addr  = addr;
          req_d.wdata = store_data;
          req_d.size  = mem_size;
          req_d.uns   = load_unsigned;
          req_d.wr    = mem_write;
          cnt_d       = WAIT_INIT;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q - 4'd1;
        if (last_busy) begin
          state_d = ST_DONE;
          mis_d   = req_mis;
          if (!req_q.wr) begin
            dout_d = req_mis ? 32'd0
                             : extract(req_q.size, req_q.addr[1:0], req_q.uns, arr_rdata);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      dout_q  <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      mis_q   <= mis_d;
    end
  end

  // The array reads every stall cycle, so its registered output always holds
  // the target word by the last BUSY cycle, even when WAIT_CYCLES is 1.
  assign arr_en    = ((state_q == ST_IDLE) && req_in) || (state_q == ST_BUSY);
  assign arr_addr  = (state_q == ST_IDLE) ? addr[ADDR_WIDTH+1:2] : req_q.addr[ADDR_WIDTH+1:2];
  assign arr_be    = (last_busy && req_q.wr && !req_mis && !rst)
                     ? byte_en(req_q.size, req_q.addr[1:0]) : 4'b0000;
  assign arr_wdata = lane_data(req_q.size, req_q.wdata);

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we_be (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign unused_addr_hi = ^req_q.addr[31:ADDR_WIDTH+2];

  assign datamem_out  = dout_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with default parameters (ADDR_WIDTH=10, WAIT_CYCLES=2).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, load_unsigned;
  logic [31:0] addr, store_data;
  logic [1:0]  mem_size;
  logic [31:0] datamem_out;
  logic        mem_stall, misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  int          stalls;
  logic [31:0] dout;
  logic        mis, mis_after, idle_stall;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .addr          (addr),
    .store_data    (store_data),
    .mem_size      (mem_size),
    .load_unsigned (load_unsigned),
    .datamem_out   (datamem_out),
    .mem_stall     (mem_stall),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // Called just after a rising edge in an IDLE cycle; returns just after the
  // edge that leaves DONE. Inputs are scrambled after the request edge so the
  // controller must be using its latched copy.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic uns);
    int n = 0;
    mem_read = rd; mem_write = wr; addr = a; store_data = d;
    mem_size = sz; load_unsigned = uns;
    stalls = 0;
    @(negedge clk);
    while (mem_stall === 1'b1 && n < 20) begin
      stalls++; n++;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; addr = ~a; store_data = ~d;
      mem_size = ~sz; load_unsigned = ~uns;
      @(negedge clk);
    end
    if (n >= 20) begin
      n_checks++;
      $display("FAIL access_timeout: stall still %b after %0d cycles, required 0", mem_stall, n);
    end
    dout = datamem_out;
    mis  = misalign_err;
    @(posedge clk); #1;
    mis_after  = misalign_err;
    idle_stall = mem_stall;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; store_data = '0;
    mem_size = W; load_unsigned = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", mem_stall); else n_pass++;
    n_checks++; if (datamem_out !== 32'd0) $display("FAIL reset_dout: got %h exp 0", datamem_out); else n_pass++;
    n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_mis: got %b exp 0", misalign_err); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, W, 1'b0);
    n_checks++; if (stalls != 3) $display("FAIL word_store_stalls: got %0d exp 3", stalls); else n_pass++;
    n_checks++; if (mis !== 1'b0) $display("FAIL word_store_mis: got %b exp 0", mis); else n_pass++;
    access(1'b1, 1'b0, 32'h10, 32'h0, W, 1'b0);
    n_checks++; if (stalls != 3) $display("FAIL word_load_stalls: got %0d exp 3", stalls); else n_pass++;
    n_checks++; if (dout !== 32'hDEADBEEF) $display("FAIL word_load_data: got %h exp deadbeef", dout); else n_pass++;
    n_checks++; if (idle_stall !== 1'b0) $display("FAIL word_idle_stall: got %b exp 0", idle_stall); else n_pass++;
  endtask

  task automatic test_byte();
    access(1'b0, 1'b1, 32'h0, 32'h0, W, 1'b0);
    access(1'b0, 1'b1, 32'h2, 32'h12345685, B, 1'b0);
    access(1'b1, 1'b0, 32'h0, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'h00850000) $display("FAIL byte_store_word: got %h exp 00850000", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h2, 32'h0, B, 1'b0);
    n_checks++; if (dout !== 32'hFFFFFF85) $display("FAIL byte_load_signed: got %h exp ffffff85", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h2, 32'h0, B, 1'b1);
    n_checks++; if (dout !== 32'h00000085) $display("FAIL byte_load_unsigned: got %h exp 00000085", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h3, 32'h0, B, 1'b0);
    n_checks++; if (dout !== 32'h00000000) $display("FAIL byte_load_lane3: got %h exp 00000000", dout); else n_pass++;
  endtask

  task automatic test_half();
    access(1'b0, 1'b1, 32'h4, 32'h11223344, W, 1'b0);
    access(1'b0, 1'b1, 32'h6, 32'hABCD8001, H, 1'b0);
    access(1'b1, 1'b0, 32'h6, 32'h0, H, 1'b0);
    n_checks++; if (dout !== 32'hFFFF8001) $display("FAIL half_load_signed: got %h exp ffff8001", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h4, 32'h0, H, 1'b1);
    n_checks++; if (dout !== 32'h00003344) $display("FAIL half_load_low: got %h exp 00003344", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h4, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'h80013344) $display("FAIL half_store_word: got %h exp 80013344", dout); else n_pass++;
  endtask

  task automatic test_misalign();
    access(1'b1, 1'b0, 32'h13, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'd0) $display("FAIL mis_word_load_data: got %h exp 00000000", dout); else n_pass++;
    n_checks++; if (mis !== 1'b1) $display("FAIL mis_word_load_pulse: got %b exp 1", mis); else n_pass++;
    n_checks++; if (mis_after !== 1'b0) $display("FAIL mis_pulse_width: got %b exp 0", mis_after); else n_pass++;
    n_checks++; if (stalls != 3) $display("FAIL mis_stalls: got %0d exp 3", stalls); else n_pass++;
    access(1'b0, 1'b1, 32'h5, 32'h0000BEEF, H, 1'b0);
    n_checks++; if (mis !== 1'b1) $display("FAIL mis_half_store_pulse: got %b exp 1", mis); else n_pass++;
    access(1'b1, 1'b0, 32'h4, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'h80013344) $display("FAIL mis_store_no_write: got %h exp 80013344", dout); else n_pass++;
    n_checks++; if (mis !== 1'b0) $display("FAIL aligned_no_mis: got %b exp 0", mis); else n_pass++;
    access(1'b1, 1'b0, 32'h7, 32'h0, H, 1'b0);
    n_checks++; if (dout !== 32'd0) $display("FAIL mis_half_load_data: got %h exp 00000000", dout); else n_pass++;
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, W, 1'b0);
    mem_write = 1'b1; mem_read = 1'b0; addr = 32'h20; store_data = 32'h12345678; mem_size = W;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b1) $display("FAIL rstmid_req_stall: got %b exp 1", mem_stall); else n_pass++;
    @(posedge clk); #1;
    mem_write = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL rstmid_stall: got %b exp 0", mem_stall); else n_pass++;
    n_checks++; if (datamem_out !== 32'd0) $display("FAIL rstmid_dout: got %h exp 00000000", datamem_out); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (mem_stall !== 1'b0) $display("FAIL rstmid_idle_hold: got %b exp 0", mem_stall); else n_pass++;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'hCAFEF00D) $display("FAIL rstmid_old_value: got %h exp cafef00d", dout); else n_pass++;
    n_checks++; if (stalls != 3) $display("FAIL rstmid_after_stalls: got %0d exp 3", stalls); else n_pass++;
  endtask

  task automatic test_simul_wrap();
    access(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, W, 1'b0);
    n_checks++; if (dout !== 32'hCAFEF00D) $display("FAIL simul_read_ignored: got %h exp cafef00d", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h40 + (32'd1 << 12), 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'hA5A5A5A5) $display("FAIL wrap_load: got %h exp a5a5a5a5", dout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 32'h10, 32'h0, W, 1'b0);
    n_checks++; if (dout !== 32'hDEADBEEF) $display("FAIL b2b_first: got %h exp deadbeef", dout); else n_pass++;
    access(1'b1, 1'b0, 32'h11, 32'h0, B, 1'b1);
    n_checks++; if (dout !== 32'h000000BE) $display("FAIL b2b_second: got %h exp 000000be", dout); else n_pass++;
    n_checks++; if (datamem_out !== 32'h000000BE) $display("FAIL b2b_hold: got %h exp 000000be", datamem_out); else n_pass++;
    access(1'b1, 1'b0, 32'h13, 32'h0, B, 1'b0);
    n_checks++; if (dout !== 32'hFFFFFFDE) $display("FAIL b2b_third: got %h exp ffffffde", dout); else n_pass++;
    n_checks++; if (stalls != 3) $display("FAIL b2b_stalls: got %0d exp 3", stalls); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_mid();
    test_simul_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
